// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// operand widths, the fixed step count and the controller state encoding.
package seq_multiplier_pkg;

    localparam int OP_WIDTH   = 8;
    localparam int PROD_WIDTH = 2 * OP_WIDTH;
    localparam int STEPS      = 8;
    localparam int CNT_WIDTH  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between a requester and the sequential multiplier.
interface seq_multiplier_if;
    import seq_multiplier_pkg::*;

    logic                  start;
    logic [OP_WIDTH-1:0]   a;
    logic [OP_WIDTH-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [PROD_WIDTH-1:0] p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/seq_multiplier_adder.sv
// Plain unsigned ripple adder with carry-in/carry-out; the multiplier's only adder.
module seq_multiplier_adder
    import seq_multiplier_pkg::*;
(
    input  logic [OP_WIDTH-1:0] a,
    input  logic [OP_WIDTH-1:0] b,
    input  logic                ci,
    output logic [OP_WIDTH-1:0] sum,
    output logic                co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{OP_WIDTH{1'b0}}, ci};

endmodule

// File: rtl/seq_multiplier.sv
// 8x8 unsigned shift-and-add multiplier: one partial-product step per clock,
// eight steps per operation, with a one-cycle DONE pulse when P is updated.
module seq_multiplier
    import seq_multiplier_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    seq_multiplier_if.slave bus
);

    state_t                state_q, state_d;
    logic [PROD_WIDTH-1:0] acc_q, acc_d;
    logic [OP_WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PROD_WIDTH-1:0] p_q, p_d;

    logic [OP_WIDTH-1:0]   add_b;
    logic [OP_WIDTH-1:0]   add_sum;
    logic                  add_co;
    logic [PROD_WIDTH-1:0] acc_step;

    // Adding zero when the multiplier bit is clear keeps a single adder path.
    assign add_b = acc_q[0] ? mcand_q : '0;

    seq_multiplier_adder u_adder (
        .a   (acc_q[PROD_WIDTH-1:OP_WIDTH]),
        .b   (add_b),
        .ci  (1'b0),
        .sum (add_sum),
        .co  (add_co)
    );

    // Carry becomes the new MSB so no partial sum is ever truncated.
    assign acc_step = {add_co, add_sum, acc_q[OP_WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    acc_d   = {{OP_WIDTH{1'b0}}, bus.b};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_WIDTH'(STEPS - 1)) begin
                    p_d     = acc_step;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_FIN);
    assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised scoreboard bench for seq_multiplier: expected products are queued
// at issue time and checked by an independent monitor whenever DONE pulses.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_multiplier_if bus ();

    seq_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] exp_q[$];
    logic [15:0] held_p;
    int          busy_len     = 0;
    bit          mon_en       = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: product on DONE, P held otherwise, BUSY run length per operation.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            checkOutput("busy_done_exclusive", 32'(bus.busy & bus.done), 32'd0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_done: got p=0x%0h, expected no DONE at %0t", bus.p, $time);
                end else begin
                    logic [15:0] exp_p;
                    exp_p = exp_q.pop_front();
                    checkOutput("product", 32'(bus.p), 32'(exp_p));
                    checkOutput("busy_cycles", 32'(busy_len), 32'd8);
                    held_p = exp_p;
                end
                busy_len = 0;
            end else begin
                checkOutput("p_held", 32'(bus.p), 32'(held_p));
                if (bus.busy) busy_len++;
            end
        end
    end

    // Waits for IDLE, issues one request and optionally keeps START high afterwards.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input int extra, input bit ff_junk);
        int waited = 0;
        while ((bus.busy || bus.done) && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (bus.busy || bus.done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL idle_timeout: got busy=%0b done=%0b, expected idle", bus.busy, bus.done);
            return;
        end
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        exp_q.push_back({8'h00, av} * {8'h00, bv});
        @(posedge clk); #1;
        for (int i = 0; i < extra; i++) begin
            bus.a = ff_junk ? 8'hFF : 8'($urandom);
            bus.b = ff_junk ? 8'hFF : 8'($urandom);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
    endtask

    initial begin
        int waited;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst    = 1'b0;
        held_p = 16'h0000;
        mon_en = 1'b1;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_p", 32'(bus.p), 32'd0);

        $display("[TB] directed operations");
        applyStimulus(8'h0F, 8'h0F, 0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 0, 1'b0);
        applyStimulus(8'h00, 8'h55, 0, 1'b0);
        applyStimulus(8'h55, 8'h00, 0, 1'b0);
        applyStimulus(8'h12, 8'h34, 9, 1'b1);

        $display("[TB] reset during RUN");
        applyStimulus(8'hAB, 8'hCD, 0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        held_p   = 16'h0000;
        busy_len = 0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_p", 32'(bus.p), 32'd0);
        applyStimulus(8'h02, 8'h03, 0, 1'b0);

        $display("[TB] random back-to-back operations");
        for (int n = 0; n < 20; n++) begin
            applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 8 bits to match the shared 8-bit adder.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  synchronous active-high reset, sampled on the CLK rising edge.
REQ-004 START  input  1  request pulse; SHALL be accepted only in IDLE.
REQ-005 A  input  8  unsigned multiplicand, sampled on the accepting edge only.
REQ-006 B  input  8  unsigned multiplier, sampled on the accepting edge only.
REQ-007 BUSY  output  1  high while an operation is in progress (state RUN).
REQ-008 DONE  output  1  one-cycle pulse; P is valid and final in that cycle.
REQ-009 P  output  16  unsigned product A*B, registered, held until the next completion or reset.

Function
REQ-010 The state machine SHALL have three states: IDLE, RUN and FIN.
REQ-011 IDLE with START=1: latch A into MCAND, B into the low half of ACC, clear the high half of ACC, clear step counter CNT, go to RUN.
REQ-012 IDLE with START=0: state, ACC, MCAND and P SHALL remain unchanged.
REQ-013 Each RUN edge performs one step: if ACC[0]=1, {C,SUM} = ACC[15:8] + MCAND via the adder with CI=0, else {C,SUM} = {0, ACC[15:8]}; then ACC <= {C, SUM, ACC[7:1]}.
REQ-014 CNT SHALL increment on every RUN edge; after the step with CNT=7, the next state SHALL be FIN and P SHALL be loaded with the final ACC.
REQ-015 Exactly 8 RUN edges per operation: with START accepted at edge k, BUSY is high for the cycles after edges k..k+7, and DONE is high for the single cycle after edge k+8.
REQ-016 FIN SHALL last exactly one cycle, then return unconditionally to IDLE; START during FIN SHALL be ignored.
REQ-017 START during RUN SHALL be ignored; operands in flight SHALL NOT change.
REQ-018 The adder carry-out SHALL be retained as ACC bit 15 each step, so no intermediate sum is truncated; the adder V output SHALL be unused (unsigned arithmetic).
REQ-019 The product SHALL be exact modulo nothing: the maximum 0xFF*0xFF = 0xFE01 fits 16 bits.
REQ-020 A and B changing outside the accepting edge SHALL have no effect on the result.
REQ-021 BUSY and DONE SHALL never be high in the same cycle.

Reset
REQ-022 RST=1 on an edge SHALL force IDLE, BUSY=0, DONE=0, P=0x0000, ACC=0, MCAND=0, CNT=0, overriding START.
REQ-023 RST asserted mid-RUN SHALL abort the operation without asserting DONE and without updating P from the partial result.
REQ-024 The first START SHALL be accepted on the first edge with RST=0.

Structure
REQ-025 The state encodings (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and the step count (8) SHALL be defined as constants in the shared CPU definitions include file, not locally.
REQ-026 Exactly one instance of the existing 8-bit adder SHALL perform all additions; there SHALL be no inline "+" on data paths.
REQ-027 CNT SHALL be 3 bits wide, and its wrap from 7 to 0 SHALL coincide with the RUN->FIN transition.

Verification
REQ-028 A=0x0F, B=0x0F, START for one cycle -> DONE 9 edges later, P=0x00E1, BUSY high for exactly 8 cycles.
REQ-029 A=0xFF, B=0xFF -> P=0xFE01 (exercises the adder carry every step).
REQ-030 A=0x00, B=0x55, then A=0x55, B=0x00 -> P=0x0000 both times, with full 8-step latency each.
REQ-031 A=0x12, B=0x34 started; START held high with A=0xFF, B=0xFF during RUN and FIN -> P=0x03A8, exactly one DONE pulse, next operation starts only from IDLE.
REQ-032 Operation started with A=0xAB, B=0xCD, RST pulsed at the 4th RUN edge -> BUSY=0, DONE never pulses, P=0x0000; a new START with A=0x02, B=0x03 -> P=0x0006.
REQ-033 Back-to-back: START reasserted in the first IDLE cycle after DONE -> the second result is correct and P holds the first result until the second DONE.
